// File: rtl/conv3x3_sliced_pim_if.sv
// Handshake and payload bundle for the bit-sliced 3x3 convolution engine.
interface conv3x3_sliced_pim_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned OUT_W = 2 * DATA_W + 4;

    logic                  in_valid;
    logic                  in_ready;
    logic [9*DATA_W-1:0]   in_data;
    logic [9*DATA_W-1:0]   kernel;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  out_sat;

    // Producer/consumer side that drives windows and takes results
    modport master (
        output in_valid, in_data, kernel, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // Convolution engine side
    modport slave (
        input  in_valid, in_data, kernel, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/conv3x3_sliced_pim.sv
// Bit-sliced 3x3 convolution: activations are fed SLICE_W bits per cycle into
// a crossbar-style dot product whose per-slice sum is clamped to the ADC range,
// then shifted into place and accumulated.
module conv3x3_sliced_pim #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SLICE_W = 2,
    parameter int unsigned ADC_P   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    conv3x3_sliced_pim_if.slave  bus
);
    localparam int unsigned NS    = DATA_W / SLICE_W;
    localparam int unsigned OUT_W = 2 * DATA_W + 4;
    localparam int unsigned SC_W  = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [OUT_W-1:0]  ADC_MAX    = {OUT_W{1'b1}} >> (OUT_W - ADC_P);
    localparam logic [DATA_W-1:0] SLICE_MASK = DATA_W'({SLICE_W{1'b1}});

    // Reject parameter sets the slicing and accumulator cannot represent
    generate
        if (((DATA_W % SLICE_W) != 0) || (ADC_P > 2 * DATA_W + 4)) begin : g_bad_params
            $error("conv3x3_sliced_pim: DATA_W must be a multiple of SLICE_W and ADC_P <= 2*DATA_W+4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [9*DATA_W-1:0]   r_x;
    logic [9*DATA_W-1:0]   r_w;
    logic [OUT_W-1:0]      r_acc;
    logic [SC_W-1:0]       r_slice;
    logic                  r_sat;

    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [OUT_W-1:0]      r_out_data;
    logic                  r_out_sat;

    logic                  w_accept;
    logic                  w_last;
    int unsigned           w_shamt;
    logic [DATA_W-1:0]     w_bits;
    logic [OUT_W-1:0]      w_psum;
    logic [OUT_W-1:0]      w_psum_clamped;
    logic                  w_clamp;
    logic [OUT_W-1:0]      w_acc_next;

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_last   = (r_slice == SC_W'(NS - 1));

    // Per-slice dot product, ADC clamp and shifted accumulation
    always_comb begin
        w_shamt = 32'(r_slice) * SLICE_W;
        w_bits  = '0;
        w_psum  = '0;
        for (int i = 0; i < 9; i++) begin
            w_bits = (r_x[i*DATA_W +: DATA_W] >> w_shamt) & SLICE_MASK;
            w_psum = w_psum + OUT_W'(w_bits) * OUT_W'(r_w[i*DATA_W +: DATA_W]);
        end
        w_clamp        = (w_psum > ADC_MAX);
        w_psum_clamped = w_clamp ? ADC_MAX : w_psum;
        w_acc_next     = r_acc + (w_psum_clamped << w_shamt);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (bus.in_valid)  w_next_state = ST_COMPUTE;
            ST_COMPUTE: if (w_last)        w_next_state = ST_DONE;
            ST_DONE:    if (bus.out_ready) w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture on accept, slice walk and accumulation during compute
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_w     <= '0;
            r_acc   <= '0;
            r_slice <= '0;
            r_sat   <= 1'b0;
        end else if (w_accept) begin
            r_x     <= bus.in_data;
            r_w     <= bus.kernel;
            r_acc   <= '0;
            r_slice <= '0;
            r_sat   <= 1'b0;
        end else if (r_state == ST_COMPUTE) begin
            r_acc   <= w_acc_next;
            r_slice <= w_last ? '0 : r_slice + SC_W'(1);
            if (w_clamp) begin
                r_sat <= 1'b1;
            end
        end
    end

    // Registered handshake and result outputs; result is zero outside DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == ST_IDLE);
            r_out_valid <= (w_next_state == ST_DONE);
            if ((r_state == ST_COMPUTE) && w_last) begin
                r_out_data <= w_acc_next;
                r_out_sat  <= r_sat | w_clamp;
            end else if (w_next_state != ST_DONE) begin
                r_out_data <= '0;
                r_out_sat  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_conv3x3_sliced_pim.sv
// Self-checking bench for conv3x3_sliced_pim: fixed vector table, corner-case
// sequences and randomized windows checked against an arithmetic reference.
module tb_conv3x3_sliced_pim;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OUT_W  = 2 * DATA_W + 4;
    localparam int unsigned TAPS_W = 9 * DATA_W;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    conv3x3_sliced_pim_if #(.DATA_W(DATA_W)) bus ();

    conv3x3_sliced_pim #(
        .DATA_W (DATA_W),
        .SLICE_W(2),
        .ADC_P  (12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAPS_W-1:0] x;
        logic [TAPS_W-1:0] w;
        logic [OUT_W-1:0]  d;
        logic              s;
        int                hold;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: slice each activation, dot with weights, clamp, weight by slice position
    function automatic void ref_model(input logic [TAPS_W-1:0] x, input logic [TAPS_W-1:0] w,
                                      output logic [OUT_W-1:0] d, output logic s);
        longint acc;
        longint p;
        int xi;
        int wi;
        acc = 0;
        s   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p = 0;
            for (int i = 0; i < 9; i++) begin
                xi = int'(x[i*8 +: 8]);
                wi = int'(w[i*8 +: 8]);
                p  = p + longint'(((xi >> (2 * k)) & 3) * wi);
            end
            if (p > 4095) begin
                p = 4095;
                s = 1'b1;
            end
            acc = acc + p * (longint'(1) << (2 * k));
        end
        d = OUT_W'(acc);
    endfunction

    function automatic logic [TAPS_W-1:0] rand_taps(input int maxv);
        logic [TAPS_W-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) begin
            v[i*8 +: 8] = 8'($urandom_range(0, maxv));
        end
        return v;
    endfunction

    // One full transaction; inputs toggle while busy, optional DONE backpressure
    task automatic run_txn(input logic [TAPS_W-1:0] x, input logic [TAPS_W-1:0] w, input int hold,
                           output logic [OUT_W-1:0] d, output logic s);
        int n;
        logic [OUT_W-1:0] d0;
        logic s0;
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'(1));
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.kernel    = w;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = rand_taps(255);
            bus.kernel   = rand_taps(255);
            check("busy_in_ready", 64'(bus.in_ready), 64'(0));
            check("busy_out_data_zero", 64'(bus.out_data), 64'(0));
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(4));
        for (int c = 0; c < hold; c++) begin
            d0 = bus.out_data;
            s0 = bus.out_sat;
            bus.in_valid = 1'b1;
            bus.in_data  = rand_taps(255);
            bus.kernel   = rand_taps(255);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_data", 64'(bus.out_data), 64'(d0));
            check("hold_sat", 64'(bus.out_sat), 64'(s0));
            check("hold_in_ready", 64'(bus.in_ready), 64'(0));
        end
        d = bus.out_data;
        s = bus.out_sat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_valid", 64'(bus.out_valid), 64'(0));
        check("post_hs_data", 64'(bus.out_data), 64'(0));
        check("post_hs_in_ready", 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        logic [OUT_W-1:0] d;
        logic             s;
        logic [OUT_W-1:0] ed;
        logic             es;
        logic [TAPS_W-1:0] rx;
        logic [TAPS_W-1:0] rw;
        int acc_times[$];
        logic [OUT_W-1:0] results[$];
        int n_acc;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{x: {9{8'd1}},   w: {9{8'd1}},   d: 20'd9,      s: 1'b0, hold: 0};
        vecs[1] = '{x: 72'd200,     w: 72'd3,       d: 20'd600,    s: 1'b0, hold: 5};
        vecs[2] = '{x: {9{8'hFF}},  w: {9{8'hFF}},  d: 20'd348075, s: 1'b1, hold: 0};
        vecs[3] = '{x: {9{8'd3}},   w: {9{8'hFF}},  d: 20'd4095,   s: 1'b1, hold: 2};
        vecs[4] = '{x: {9{8'd2}},   w: {9{8'd227}}, d: 20'd4086,   s: 1'b0, hold: 0};
        vecs[5] = '{x: {9{8'hC0}},  w: {9{8'd1}},   d: 20'd1728,   s: 1'b0, hold: 1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.kernel    = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_out_data", 64'(bus.out_data), 64'(0));
        check("reset_out_sat", 64'(bus.out_sat), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fixed vectors
        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].x, vecs[v].w, vecs[v].hold, d, s);
            check($sformatf("vec%0d_data", v), 64'(d), 64'(vecs[v].d));
            check($sformatf("vec%0d_sat", v), 64'(s), 64'(vecs[v].s));
        end

        // Reset during the third compute cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = {9{8'hFF}};
        bus.kernel   = {9{8'hFF}};
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        check("midrst_out_data", 64'(bus.out_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("midrst_no_valid", 64'(bus.out_valid), 64'(0));
        end
        run_txn({9{8'd1}}, {9{8'd1}}, 0, d, s);
        check("midrst_fresh_data", 64'(d), 64'(9));
        check("midrst_fresh_sat", 64'(s), 64'(0));

        // Back-to-back with in_valid held high
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = {9{8'd1}};
        bus.kernel    = {9{8'd1}};
        bus.out_ready = 1'b1;
        n_acc = 0;
        for (int cyc = 0; cyc < 40 && results.size() < 2; cyc++) begin
            if (bus.in_valid && bus.in_ready) begin
                acc_times.push_back(cyc);
                n_acc++;
            end
            if (bus.out_valid) results.push_back(bus.out_data);
            @(posedge clk);
            @(negedge clk);
            if (n_acc == 1) begin
                bus.in_data = 72'd200;
                bus.kernel  = 72'd3;
            end else if (n_acc >= 2) begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_n_results", 64'(results.size()), 64'(2));
        check("b2b_n_accepts", 64'(acc_times.size()), 64'(2));
        if (results.size() == 2) begin
            check("b2b_first", 64'(results[0]), 64'(9));
            check("b2b_second", 64'(results[1]), 64'(600));
        end
        if (acc_times.size() == 2) begin
            check("b2b_spacing", 64'(acc_times[1] - acc_times[0]), 64'(6));
        end
        repeat (2) @(negedge clk);

        // Randomized windows against the reference
        for (int t = 0; t < 24; t++) begin
            rx = rand_taps(255);
            rw = rand_taps(($urandom_range(0, 1) == 1) ? 255 : 31);
            ref_model(rx, rw, ed, es);
            run_txn(rx, rw, int'($urandom_range(0, 3)), d, s);
            check($sformatf("rand%0d_data", t), 64'(d), 64'(ed));
            check($sformatf("rand%0d_sat", t), 64'(s), 64'(es));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
